// File: rtl/ram_write_arbiter.sv
// rtl/ram_write_arbiter.sv - two-requester round-robin write arbiter for the DDR3 native app port
//
// Purpose: shares one single-beat write channel between the la0 and la1
// capture writers. The winner's request is copied into a one-entry holding
// stage. It is then issued as a command half (app_en) and a data half
// (app_wdf_wren), and each half is tracked separately.
//
// Ports:
//   clk_ram, rst_n          clock and asynchronous active-low reset
//   ram_ready               DDR calibration complete; gates new grants only
//   laN_wr_en/addr/data     level request from writer N (N = 0, 1)
//   laN_wr_ack              one-cycle pulse: request N captured into hold
//   app_en/cmd/addr/rdy     command half of the native app port
//   app_wdf_*               data half of the native app port
//
// Optional feature macro: RAM_WRITE_ARB_STATS_EN
//   Adds stat_clear, stat_wr_count0, stat_wr_count1 and stat_stall_cycles.
//   These are saturating 32-bit counters.
module ram_write_arbiter #(
  parameter int ADDR_WIDTH = 29,
  parameter int DATA_WIDTH = 128
) (
  input  logic                    clk_ram,
  input  logic                    rst_n,
  input  logic                    ram_ready,
  input  logic                    la0_wr_en,
  input  logic [ADDR_WIDTH-1:0]   la0_wr_addr,
  input  logic [DATA_WIDTH-1:0]   la0_wr_data,
  output logic                    la0_wr_ack,
  input  logic                    la1_wr_en,
  input  logic [ADDR_WIDTH-1:0]   la1_wr_addr,
  input  logic [DATA_WIDTH-1:0]   la1_wr_data,
  output logic                    la1_wr_ack,
  output logic                    app_en,
  output logic [2:0]              app_cmd,
  output logic [ADDR_WIDTH-1:0]   app_addr,
  input  logic                    app_rdy,
  output logic                    app_wdf_wren,
  output logic [DATA_WIDTH-1:0]   app_wdf_data,
  output logic                    app_wdf_end,
  output logic [DATA_WIDTH/8-1:0] app_wdf_mask,
  input  logic                    app_wdf_rdy
`ifdef RAM_WRITE_ARB_STATS_EN
  ,
  input  logic                    stat_clear,
  output logic [31:0]             stat_wr_count0,
  output logic [31:0]             stat_wr_count1,
  output logic [31:0]             stat_stall_cycles
`endif
);

  logic                  hold_valid;
  logic [ADDR_WIDTH-1:0] hold_addr;
  logic [DATA_WIDTH-1:0] hold_data;
  logic                  cmd_done;
  logic                  data_done;
  logic                  last_grant;  // 0: la0 won last, 1: la1 won last

  logic cmd_fire;
  logic data_fire;
  logic write_finish;
  logic hold_free;
  logic elig0;
  logic elig1;
  logic grant0;
  logic grant1;

  // Both halves are issued straight from the hold registers.
  assign app_en       = hold_valid & ~cmd_done;
  assign app_wdf_wren = hold_valid & ~data_done;
  assign app_wdf_end  = app_wdf_wren;
  assign app_cmd      = 3'b000;
  assign app_addr     = hold_addr;
  assign app_wdf_data = hold_data;
  assign app_wdf_mask = '0;

  assign cmd_fire  = app_en & app_rdy;
  assign data_fire = app_wdf_wren & app_wdf_rdy;

  // The write retires on the edge where its last outstanding half is
  // accepted. The halves may be accepted in either order or together.
  assign write_finish = hold_valid & (cmd_done | cmd_fire) & (data_done | data_fire);
  assign hold_free    = ~hold_valid | write_finish;

  // A request whose ack is high this cycle was already captured. The writer
  // has not yet seen the ack, so that request must not be taken twice.
  assign elig0 = la0_wr_en & ~la0_wr_ack;
  assign elig1 = la1_wr_en & ~la1_wr_ack;

  // Round-robin: when both are eligible, the one that did not win last wins.
  assign grant0 = hold_free & ram_ready & elig0 & (~elig1 | last_grant);
  assign grant1 = hold_free & ram_ready & elig1 & (~elig0 | ~last_grant);

  always_ff @(posedge clk_ram or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid <= 1'b0;
      hold_addr  <= '0;
      hold_data  <= '0;
      cmd_done   <= 1'b0;
      data_done  <= 1'b0;
      last_grant <= 1'b1;
      la0_wr_ack <= 1'b0;
      la1_wr_ack <= 1'b0;
    end else begin
      la0_wr_ack <= grant0;
      la1_wr_ack <= grant1;
      if (grant0 | grant1) begin
        // A grant only happens when the hold is free, so it may replace a
        // write that retires on this same edge.
        hold_valid <= 1'b1;
        hold_addr  <= grant0 ? la0_wr_addr : la1_wr_addr;
        hold_data  <= grant0 ? la0_wr_data : la1_wr_data;
        cmd_done   <= 1'b0;
        data_done  <= 1'b0;
        last_grant <= grant1;
      end else if (write_finish) begin
        hold_valid <= 1'b0;
        cmd_done   <= 1'b0;
        data_done  <= 1'b0;
      end else begin
        if (cmd_fire)  cmd_done  <= 1'b1;
        if (data_fire) data_done <= 1'b1;
      end
    end
  end

`ifdef RAM_WRITE_ARB_STATS_EN
  logic stall;

  // A cycle counts as stalled when a write is held but does not retire.
  assign stall = hold_valid & ~write_finish;

  always_ff @(posedge clk_ram or negedge rst_n) begin
    if (!rst_n) begin
      stat_wr_count0    <= '0;
      stat_wr_count1    <= '0;
      stat_stall_cycles <= '0;
    end else if (stat_clear) begin
      stat_wr_count0    <= '0;
      stat_wr_count1    <= '0;
      stat_stall_cycles <= '0;
    end else begin
      if (grant0 && (stat_wr_count0 != 32'hFFFF_FFFF))
        stat_wr_count0 <= stat_wr_count0 + 32'd1;
      if (grant1 && (stat_wr_count1 != 32'hFFFF_FFFF))
        stat_wr_count1 <= stat_wr_count1 + 32'd1;
      if (stall && (stat_stall_cycles != 32'hFFFF_FFFF))
        stat_stall_cycles <= stat_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ram_write_arbiter.sv
// tb/tb_ram_write_arbiter.sv - self-checking bench for ram_write_arbiter
module tb_ram_write_arbiter;

  logic         clk_ram = 1'b0;
  logic         rst_n = 1'b0;
  logic         ram_ready = 1'b1;
  logic         la0_wr_en = 1'b0;
  logic [28:0]  la0_wr_addr = '0;
  logic [127:0] la0_wr_data = '0;
  logic         la0_wr_ack;
  logic         la1_wr_en = 1'b0;
  logic [28:0]  la1_wr_addr = '0;
  logic [127:0] la1_wr_data = '0;
  logic         la1_wr_ack;
  logic         app_en;
  logic [2:0]   app_cmd;
  logic [28:0]  app_addr;
  logic         app_rdy = 1'b1;
  logic         app_wdf_wren;
  logic [127:0] app_wdf_data;
  logic         app_wdf_end;
  logic [15:0]  app_wdf_mask;
  logic         app_wdf_rdy = 1'b1;
`ifdef RAM_WRITE_ARB_STATS_EN
  logic         stat_clear = 1'b0;
  logic [31:0]  stat_wr_count0;
  logic [31:0]  stat_wr_count1;
  logic [31:0]  stat_stall_cycles;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk_ram = ~clk_ram;

  ram_write_arbiter #(.ADDR_WIDTH(29), .DATA_WIDTH(128)) dut (
    .clk_ram(clk_ram), .rst_n(rst_n), .ram_ready(ram_ready),
    .la0_wr_en(la0_wr_en), .la0_wr_addr(la0_wr_addr), .la0_wr_data(la0_wr_data),
    .la0_wr_ack(la0_wr_ack),
    .la1_wr_en(la1_wr_en), .la1_wr_addr(la1_wr_addr), .la1_wr_data(la1_wr_data),
    .la1_wr_ack(la1_wr_ack),
    .app_en(app_en), .app_cmd(app_cmd), .app_addr(app_addr), .app_rdy(app_rdy),
    .app_wdf_wren(app_wdf_wren), .app_wdf_data(app_wdf_data),
    .app_wdf_end(app_wdf_end), .app_wdf_mask(app_wdf_mask), .app_wdf_rdy(app_wdf_rdy)
`ifdef RAM_WRITE_ARB_STATS_EN
    ,
    .stat_clear(stat_clear), .stat_wr_count0(stat_wr_count0),
    .stat_wr_count1(stat_wr_count1), .stat_stall_cycles(stat_stall_cycles)
`endif
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: the pending write as a transaction plus the arbiter's
  // memory of who won last.
  typedef struct {
    bit           busy;
    logic [28:0]  addr;
    logic [127:0] data;
    bit           cmd_ok;
    bit           dat_ok;
    int           prev;
    bit           ack0;
    bit           ack1;
    logic [31:0]  c0;
    logic [31:0]  c1;
    logic [31:0]  cs;
  } ms_t;

  ms_t m;
  ms_t n;

  function automatic ms_t reset_state();
    ms_t s;
    s.busy = 0; s.addr = '0; s.data = '0; s.cmd_ok = 0; s.dat_ok = 0;
    s.prev = 1; s.ack0 = 0; s.ack1 = 0; s.c0 = '0; s.c1 = '0; s.cs = '0;
    return s;
  endfunction

  function automatic logic [31:0] sat(input logic [31:0] v, input bit inc);
    if (inc && v != 32'hFFFF_FFFF) return v + 32'd1;
    return v;
  endfunction

  initial begin
    m = reset_state();
    n = m;
  end

  // Compare process: checks every output against the model on each falling
  // edge, then works out what the model must look like after the next edge.
  always @(negedge clk_ram) begin
    bit en_e, wr_e, fc, fd, fin, w0, w1, clr;
    int who;
    if (!rst_n) begin
      m = reset_state();
      n = m;
    end
    en_e = m.busy && !m.cmd_ok;
    wr_e = m.busy && !m.dat_ok;
    chk("ack0", la0_wr_ack, m.ack0);
    chk("ack1", la1_wr_ack, m.ack1);
    chk("app_en", app_en, en_e);
    chk("app_wdf_wren", app_wdf_wren, wr_e);
    chk("app_wdf_end", app_wdf_end, wr_e);
    chk("app_cmd", app_cmd, 3'b000);
    chk("app_wdf_mask", app_wdf_mask, 16'h0);
    if (m.busy) begin
      chk("app_addr", app_addr, m.addr);
      chk("app_wdf_data", app_wdf_data, m.data);
    end
`ifdef RAM_WRITE_ARB_STATS_EN
    chk("stat_wr_count0", stat_wr_count0, m.c0);
    chk("stat_wr_count1", stat_wr_count1, m.c1);
    chk("stat_stall_cycles", stat_stall_cycles, m.cs);
    clr = stat_clear;
`else
    clr = 0;
`endif
    if (rst_n) begin
      fc = en_e && app_rdy;
      fd = wr_e && app_wdf_rdy;
      fin = m.busy && (m.cmd_ok || fc) && (m.dat_ok || fd);
      n = m;
      n.ack0 = 0;
      n.ack1 = 0;
      if (m.busy) begin
        n.cmd_ok = m.cmd_ok || fc;
        n.dat_ok = m.dat_ok || fd;
      end
      if (fin) begin
        n.busy = 0; n.cmd_ok = 0; n.dat_ok = 0;
      end
      w0 = la0_wr_en && !m.ack0;
      w1 = la1_wr_en && !m.ack1;
      who = -1;
      if ((!m.busy || fin) && ram_ready && (w0 || w1)) begin
        if (w0 && w1) who = 1 - m.prev;
        else who = w0 ? 0 : 1;
        n.busy = 1; n.cmd_ok = 0; n.dat_ok = 0; n.prev = who;
        n.addr = (who == 0) ? la0_wr_addr : la1_wr_addr;
        n.data = (who == 0) ? la0_wr_data : la1_wr_data;
        if (who == 0) n.ack0 = 1; else n.ack1 = 1;
      end
      if (clr) begin
        n.c0 = '0; n.c1 = '0; n.cs = '0;
      end else begin
        n.c0 = sat(m.c0, who == 0);
        n.c1 = sat(m.c1, who == 1);
        n.cs = sat(m.cs, m.busy && !fin);
      end
    end
  end

  always @(posedge clk_ram or negedge rst_n) begin
    if (!rst_n) m = reset_state();
    else m = n;
  end

  task automatic tick();
    @(posedge clk_ram);
    #1;
  endtask

  task automatic reset_dut();
    rst_n = 0;
    la0_wr_en = 0; la1_wr_en = 0;
    ram_ready = 1; app_rdy = 1; app_wdf_rdy = 1;
    tick();
    tick();
    chk("rst ack0", la0_wr_ack, 1'b0);
    chk("rst ack1", la1_wr_ack, 1'b0);
    chk("rst app_en", app_en, 1'b0);
    chk("rst wren", app_wdf_wren, 1'b0);
    chk("rst wdf_end", app_wdf_end, 1'b0);
    chk("rst app_addr", app_addr, 29'h0);
    chk("rst wdf_data", app_wdf_data, 128'h0);
    rst_n = 1;
  endtask

  bit p0, p1, pa0, pa1;
  int na0, na1, en_cycles;

  initial begin
    // Single write
    reset_dut();
    la0_wr_en = 1; la0_wr_addr = 29'h0000100; la0_wr_data = {16{8'hA5}};
    tick();
    chk("single ack0", la0_wr_ack, 1'b1);
    chk("single ack1", la1_wr_ack, 1'b0);
    chk("single app_en", app_en, 1'b1);
    chk("single app_addr", app_addr, 29'h0000100);
    chk("single app_cmd", app_cmd, 3'b000);
    chk("single wdf_data", app_wdf_data, {16{8'hA5}});
    chk("single wdf_end", app_wdf_end, 1'b1);
    tick();
    la0_wr_en = 0;
    chk("single ack0 one pulse", la0_wr_ack, 1'b0);
    chk("single app_en one cycle", app_en, 1'b0);
    tick();

    // Both requesting continuously: strict alternation starting at la0
    reset_dut();
    la0_wr_en = 1; la0_wr_addr = 29'h10; la0_wr_data = 128'h1000;
    la1_wr_en = 1; la1_wr_addr = 29'h20; la1_wr_data = 128'h2000;
    na0 = 0; na1 = 0; pa0 = 0; pa1 = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (pa0) begin la0_wr_addr = la0_wr_addr + 29'd1; la0_wr_data = la0_wr_data + 128'd1; end
      if (pa1) begin la1_wr_addr = la1_wr_addr + 29'd1; la1_wr_data = la1_wr_data + 128'd1; end
      pa0 = la0_wr_ack; pa1 = la1_wr_ack;
      if (la0_wr_ack) na0++;
      if (la1_wr_ack) na1++;
      chk("alt ack0", la0_wr_ack, (i % 2) == 0);
      chk("alt ack1", la1_wr_ack, (i % 2) == 1);
      chk("alt model ack0", m.ack0, (i % 2) == 0);
      chk("alt app_en", app_en, 1'b1);
    end
    chk("alt la0 acks", na0, 4);
    chk("alt la1 acks", na1, 4);
    tick();
    la0_wr_en = 0; la1_wr_en = 0;
    tick();
    tick();

    // Command stalled three cycles, data accepted immediately
    reset_dut();
    app_rdy = 0;
    la0_wr_en = 1; la0_wr_addr = 29'h0AAAAAA; la0_wr_data = 128'h55;
    en_cycles = 0;
    tick();
    chk("stall c1 ack0", la0_wr_ack, 1'b1);
    chk("stall c1 wren", app_wdf_wren, 1'b1);
    if (app_en) en_cycles++;
    la1_wr_en = 1; la1_wr_addr = 29'h0123456; la1_wr_data = 128'h66;
    tick();
    la0_wr_en = 0;
    chk("stall c2 wren", app_wdf_wren, 1'b0);
    chk("stall c2 ack1", la1_wr_ack, 1'b0);
    if (app_en) en_cycles++;
    tick();
    chk("stall c3 ack1", la1_wr_ack, 1'b0);
    if (app_en) en_cycles++;
    tick();
    app_rdy = 1;
    chk("stall c4 wren", app_wdf_wren, 1'b0);
    chk("stall c4 ack1", la1_wr_ack, 1'b0);
    if (app_en) en_cycles++;
    chk("stall app_en cycles", en_cycles, 4);
    tick();
    chk("stall c5 ack1", la1_wr_ack, 1'b1);
    chk("stall c5 app_addr", app_addr, 29'h0123456);
    tick();
    la1_wr_en = 0;
    tick();

    // ram_ready low blocks grants
    reset_dut();
    ram_ready = 0;
    la1_wr_en = 1; la1_wr_addr = 29'h77; la1_wr_data = 128'h77;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("notready ack1", la1_wr_ack, 1'b0);
      chk("notready app_en", app_en, 1'b0);
    end
    ram_ready = 1;
    tick();
    chk("ready ack1", la1_wr_ack, 1'b1);
    tick();
    la1_wr_en = 0;
    tick();

    // Reset in the middle of a stalled write, then tie goes to la0
    reset_dut();
    app_rdy = 0;
    la0_wr_en = 1; la0_wr_addr = 29'h99; la0_wr_data = 128'h99;
    tick();
    tick();
    chk("pre-rst app_en", app_en, 1'b1);
    #2;
    rst_n = 0;
    #1;
    chk("mid-rst app_en", app_en, 1'b0);
    chk("mid-rst wren", app_wdf_wren, 1'b0);
    chk("mid-rst wdf_end", app_wdf_end, 1'b0);
    chk("mid-rst app_addr", app_addr, 29'h0);
    chk("mid-rst wdf_data", app_wdf_data, 128'h0);
    chk("mid-rst ack0", la0_wr_ack, 1'b0);
    app_rdy = 1;
    la1_wr_en = 1; la1_wr_addr = 29'h88; la1_wr_data = 128'h88;
    tick();
    rst_n = 1;
    tick();
    chk("post-rst tie ack0", la0_wr_ack, 1'b1);
    chk("post-rst tie ack1", la1_wr_ack, 1'b0);
    tick();
    la0_wr_en = 0;
    chk("post-rst second ack1", la1_wr_ack, 1'b1);
    tick();
    la1_wr_en = 0;
    tick();

    // Randomized traffic against the model
    reset_dut();
    p0 = 0; p1 = 0; pa0 = 0; pa1 = 0;
    for (int i = 0; i < 4000; i++) begin
      tick();
      if (pa0) p0 = 0;
      if (pa1) p1 = 0;
      pa0 = la0_wr_ack;
      pa1 = la1_wr_ack;
      if (!p0 && $urandom_range(0, 99) < 60) begin
        p0 = 1;
        la0_wr_addr = 29'($urandom);
        la0_wr_data = {$urandom, $urandom, $urandom, $urandom};
      end
      if (!p1 && $urandom_range(0, 99) < 60) begin
        p1 = 1;
        la1_wr_addr = 29'($urandom);
        la1_wr_data = {$urandom, $urandom, $urandom, $urandom};
      end
      la0_wr_en = p0;
      la1_wr_en = p1;
      app_rdy = $urandom_range(0, 99) < 70;
      app_wdf_rdy = $urandom_range(0, 99) < 70;
      ram_ready = $urandom_range(0, 99) < 90;
`ifdef RAM_WRITE_ARB_STATS_EN
      stat_clear = $urandom_range(0, 99) < 2;
`endif
    end
    la0_wr_en = 0;
    la1_wr_en = 0;
    app_rdy = 1;
    app_wdf_rdy = 1;
    ram_ready = 1;
    for (int i = 0; i < 5; i++) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
